// File: rtl/sram_arbiter_pkg.sv
// ============================================================================
//  Module      : sram_arbiter_pkg
//  Description : Shared FSM state encodings and grant ids for the SRAM arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_ISSUE = 2'd1;
    localparam logic [1:0] ARB_WAIT  = 2'd2;
    localparam logic [1:0] ARB_RESP  = 2'd3;

    localparam logic ARB_GNT_I = 1'b0;
    localparam logic ARB_GNT_D = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sram_arb_pick.sv
// ============================================================================
//  Module      : sram_arb_pick
//  Description : Combinational winner select for the I/D SRAM arbiter.
//                SRAM_ARB_RR_EN selects round-robin ties, else D wins ties.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arb_pick
    import sram_arbiter_pkg::*;
(
    input  logic i_i_req,
    input  logic i_d_req,
    input  logic i_last_gnt,
    output logic o_gnt
);

    logic w_tie_gnt;

`ifdef SRAM_ARB_RR_EN
    // Grant ids are single-bit, so the other requester is the inverse.
    assign w_tie_gnt = ~i_last_gnt;
`else
    logic w_unused_last_gnt;
    assign w_unused_last_gnt = i_last_gnt;
    assign w_tie_gnt         = ARB_GNT_D;
`endif

    always_comb begin
        o_gnt = ARB_GNT_I;
        if (i_i_req && i_d_req) begin
            o_gnt = w_tie_gnt;
        end else if (i_d_req) begin
            o_gnt = ARB_GNT_D;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ============================================================================
//  Module      : sram_arbiter
//  Description : Shares one SRAM line port between I-side and D-side caches.
//                Optional macro SRAM_ARB_RR_EN enables round-robin ties.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int SRAM_ADDR_BIT = 12,
    parameter int SRAM_DATA_BIT = 128,
    parameter int SRAM_LAT      = 1,
    parameter int CNT_BIT       = 32
) (
    input  logic                     clk_sys_i,
    input  logic                     rst_sys_i,
    input  logic                     I_req_i,
    input  logic                     I_wea_i,
    input  logic [SRAM_ADDR_BIT-1:0] I_addr_i,
    input  logic [SRAM_DATA_BIT-1:0] I_data_i,
    output logic                     I_ack_o,
    output logic [SRAM_DATA_BIT-1:0] I_data_o,
    input  logic                     D_req_i,
    input  logic                     D_wea_i,
    input  logic [SRAM_ADDR_BIT-1:0] D_addr_i,
    input  logic [SRAM_DATA_BIT-1:0] D_data_i,
    output logic                     D_ack_o,
    output logic [SRAM_DATA_BIT-1:0] D_data_o,
    output logic                     SRAM_ena_o,
    output logic                     SRAM_wea_o,
    output logic [SRAM_ADDR_BIT-1:0] SRAM_addr_o,
    output logic [SRAM_DATA_BIT-1:0] SRAM_data_o,
    input  logic [SRAM_DATA_BIT-1:0] SRAM_data_i,
    output logic                     busy_o,
    output logic [CNT_BIT-1:0]       conflict_cnt_o
);

    localparam int                    c_WCNT_BIT  = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;
    localparam logic [c_WCNT_BIT-1:0] c_WCNT_LOAD = c_WCNT_BIT'(SRAM_LAT - 1);

    logic [1:0]               r_state;
    logic                     r_gnt;
    logic [c_WCNT_BIT-1:0]    r_wcnt;
    logic                     r_sram_ena;
    logic                     r_sram_wea;
    logic [SRAM_ADDR_BIT-1:0] r_sram_addr;
    logic [SRAM_DATA_BIT-1:0] r_sram_data;
    logic                     r_i_ack;
    logic                     r_d_ack;
    logic [SRAM_DATA_BIT-1:0] r_i_data;
    logic [SRAM_DATA_BIT-1:0] r_d_data;
    logic                     r_busy;
    logic [CNT_BIT-1:0]       r_conflict_cnt;

    logic w_pick;
    logic w_last_gnt;
    logic w_tie;
    logic w_any_req;

    assign w_tie     = I_req_i & D_req_i;
    assign w_any_req = I_req_i | D_req_i;

`ifdef SRAM_ARB_RR_EN
    logic r_last_gnt;

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_last_gnt <= ARB_GNT_D;
        end else if (r_state == ARB_IDLE && w_any_req) begin
            r_last_gnt <= w_pick;
        end
    end

    assign w_last_gnt = r_last_gnt;
`else
    assign w_last_gnt = ARB_GNT_D;
`endif

    sram_arb_pick u_pick (
        .i_i_req    (I_req_i),
        .i_d_req    (D_req_i),
        .i_last_gnt (w_last_gnt),
        .o_gnt      (w_pick)
    );

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_state        <= ARB_IDLE;
            r_gnt          <= ARB_GNT_I;
            r_wcnt         <= '0;
            r_sram_ena     <= 1'b0;
            r_sram_wea     <= 1'b0;
            r_sram_addr    <= '0;
            r_sram_data    <= '0;
            r_i_ack        <= 1'b0;
            r_d_ack        <= 1'b0;
            r_i_data       <= '0;
            r_d_data       <= '0;
            r_busy         <= 1'b0;
            r_conflict_cnt <= '0;
        end else begin
            r_sram_ena <= 1'b0;
            r_i_ack    <= 1'b0;
            r_d_ack    <= 1'b0;

            if (r_state == ARB_IDLE && w_tie && r_conflict_cnt != '1) begin
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
            end

            case (r_state)
                ARB_IDLE: begin
                    if (w_any_req) begin
                        r_gnt       <= w_pick;
                        r_sram_wea  <= (w_pick == ARB_GNT_D) ? D_wea_i  : I_wea_i;
                        r_sram_addr <= (w_pick == ARB_GNT_D) ? D_addr_i : I_addr_i;
                        r_sram_data <= (w_pick == ARB_GNT_D) ? D_data_i : I_data_i;
                        r_sram_ena  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    r_wcnt  <= c_WCNT_LOAD;
                    r_state <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (r_wcnt == '0) begin
                        // Read data is valid on the port during the last WAIT cycle.
                        if (!r_sram_wea) begin
                            if (r_gnt == ARB_GNT_D) r_d_data <= SRAM_data_i;
                            else                    r_i_data <= SRAM_data_i;
                        end
                        if (r_gnt == ARB_GNT_D) r_d_ack <= 1'b1;
                        else                    r_i_ack <= 1'b1;
                        r_state <= ARB_RESP;
                    end else begin
                        r_wcnt <= r_wcnt - 1'b1;
                    end
                end
                ARB_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= ARB_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign I_ack_o        = r_i_ack;
    assign D_ack_o        = r_d_ack;
    assign I_data_o       = r_i_data;
    assign D_data_o       = r_d_data;
    assign SRAM_ena_o     = r_sram_ena;
    assign SRAM_wea_o     = r_sram_wea;
    assign SRAM_addr_o    = r_sram_addr;
    assign SRAM_data_o    = r_sram_data;
    assign busy_o         = r_busy;
    assign conflict_cnt_o = r_conflict_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
//  Module      : tb_sram_arbiter
//  Description : Self-checking bench for sram_arbiter at SRAM_LAT 1 and 3.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_arbiter;

    logic         clk;
    logic         rst       [2];
    logic         i_req     [2];
    logic         d_req     [2];
    logic         i_wea     [2];
    logic         d_wea     [2];
    logic [11:0]  i_addr    [2];
    logic [11:0]  d_addr    [2];
    logic [127:0] i_wdata   [2];
    logic [127:0] d_wdata   [2];
    logic         i_ack     [2];
    logic         d_ack     [2];
    logic [127:0] i_rdata   [2];
    logic [127:0] d_rdata   [2];
    logic         sram_ena  [2];
    logic         sram_wea  [2];
    logic [11:0]  sram_addr [2];
    logic [127:0] sram_wdata[2];
    logic [127:0] sram_rd   [2];
    logic         busy      [2];
    logic [3:0]   cnt       [2];

    int           checks;
    int           errors;

    // Reference model state
    int           cnt_m  [2];
    logic         last_m [2];
    logic [127:0] exp_i  [2];
    logic [127:0] exp_d  [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        sram_arbiter #(
            .SRAM_ADDR_BIT (12),
            .SRAM_DATA_BIT (128),
            .SRAM_LAT      ((k == 0) ? 1 : 3),
            .CNT_BIT       (4)
        ) u_dut (
            .clk_sys_i      (clk),
            .rst_sys_i      (rst[k]),
            .I_req_i        (i_req[k]),
            .I_wea_i        (i_wea[k]),
            .I_addr_i       (i_addr[k]),
            .I_data_i       (i_wdata[k]),
            .I_ack_o        (i_ack[k]),
            .I_data_o       (i_rdata[k]),
            .D_req_i        (d_req[k]),
            .D_wea_i        (d_wea[k]),
            .D_addr_i       (d_addr[k]),
            .D_data_i       (d_wdata[k]),
            .D_ack_o        (d_ack[k]),
            .D_data_o       (d_rdata[k]),
            .SRAM_ena_o     (sram_ena[k]),
            .SRAM_wea_o     (sram_wea[k]),
            .SRAM_addr_o    (sram_addr[k]),
            .SRAM_data_o    (sram_wdata[k]),
            .SRAM_data_i    (sram_rd[k]),
            .busy_o         (busy[k]),
            .conflict_cnt_o (cnt[k])
        );
    end

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Winner rule: lone requester wins; ties go to D, or alternate under round-robin.
    function automatic logic pick(input int k, input logic ir, input logic dr);
        if (ir && dr) begin
`ifdef SRAM_ARB_RR_EN
            return ~last_m[k];
`else
            return 1'b1;
`endif
        end
        return dr;
    endfunction

    task automatic chk(input int k, input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL k%0d %s observed=%h expected=%h", k, tag, obs, exp);
        end
    endtask

    // Outputs are sampled on the falling edge; SRAM read data changes there too.
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) sram_rd[k] = rnd128();
    endtask

    task automatic chk_all_zero(input int k);
        chk(k, "rst_i_ack", 128'(i_ack[k]), '0);
        chk(k, "rst_d_ack", 128'(d_ack[k]), '0);
        chk(k, "rst_ena", 128'(sram_ena[k]), '0);
        chk(k, "rst_wea", 128'(sram_wea[k]), '0);
        chk(k, "rst_addr", 128'(sram_addr[k]), '0);
        chk(k, "rst_wdata", sram_wdata[k], '0);
        chk(k, "rst_i_data", i_rdata[k], '0);
        chk(k, "rst_d_data", d_rdata[k], '0);
        chk(k, "rst_busy", 128'(busy[k]), '0);
        chk(k, "rst_cnt", 128'(cnt[k]), '0);
    endtask

    task automatic lone(input int k, input logic side, input logic wea,
                        input logic [11:0] addr, input logic [127:0] data);
        int           L;
        logic [127:0] cap;
        L   = lat(k);
        cap = '0;
        if (side) begin
            d_req[k] = 1'b1; d_wea[k] = wea; d_addr[k] = addr; d_wdata[k] = data;
        end else begin
            i_req[k] = 1'b1; i_wea[k] = wea; i_addr[k] = addr; i_wdata[k] = data;
        end
        last_m[k] = pick(k, !side, side);
        for (int c = 1; c <= 3 + L; c++) begin
            tick();
            chk(k, "ena", 128'(sram_ena[k]), 128'(c == 1));
            chk(k, "busy", 128'(busy[k]), 128'(c <= 2 + L));
            chk(k, "i_ack", 128'(i_ack[k]), 128'((c == 2 + L) && !side));
            chk(k, "d_ack", 128'(d_ack[k]), 128'((c == 2 + L) && side));
            if (c == 1) begin
                chk(k, "addr", 128'(sram_addr[k]), 128'(addr));
                chk(k, "wea", 128'(sram_wea[k]), 128'(wea));
                if (wea) chk(k, "wdata", sram_wdata[k], data);
                chk(k, "cnt", 128'(cnt[k]), 128'(cnt_m[k]));
                // Command changes after grant must not leak into this access.
                if (side) begin
                    d_wea[k] = ~wea; d_addr[k] = 12'($urandom()); d_wdata[k] = rnd128();
                end else begin
                    i_wea[k] = ~wea; i_addr[k] = 12'($urandom()); i_wdata[k] = rnd128();
                end
            end
            if (c == 1 + L) cap = sram_rd[k];
            if (c == 2 + L) begin
                if (!wea) begin
                    if (side) exp_d[k] = cap;
                    else      exp_i[k] = cap;
                end
                chk(k, "i_data", i_rdata[k], exp_i[k]);
                chk(k, "d_data", d_rdata[k], exp_d[k]);
                if (side) d_req[k] = 1'b0;
                else      i_req[k] = 1'b0;
            end
        end
    endtask

    task automatic tie(input int k, input int n);
        int           L;
        logic         w;
        logic [127:0] cap;
        L   = lat(k);
        cap = '0;
        i_req[k] = 1'b1; i_wea[k] = 1'b0; i_addr[k] = 12'h0AA;
        d_req[k] = 1'b1; d_wea[k] = 1'b0; d_addr[k] = 12'h0DD;
        for (int g = 0; g < n; g++) begin
            if (g > 0) tick();
            if (cnt_m[k] < 15) cnt_m[k]++;
            w         = pick(k, 1'b1, 1'b1);
            last_m[k] = w;
            for (int c = 1; c <= 2 + L; c++) begin
                tick();
                if (c == 1) begin
                    chk(k, "tie_addr", 128'(sram_addr[k]), w ? 128'h0DD : 128'h0AA);
                    chk(k, "tie_cnt", 128'(cnt[k]), 128'(cnt_m[k]));
                end
                if (c == 1 + L) cap = sram_rd[k];
                if (c == 2 + L) begin
                    if (w) exp_d[k] = cap;
                    else   exp_i[k] = cap;
                    chk(k, "tie_i_ack", 128'(i_ack[k]), 128'(!w));
                    chk(k, "tie_d_ack", 128'(d_ack[k]), 128'(w));
                    chk(k, "tie_data", w ? d_rdata[k] : i_rdata[k], cap);
                end
            end
        end
        i_req[k] = 1'b0;
        d_req[k] = 1'b0;
        tick();
        chk(k, "tie_end_busy", 128'(busy[k]), '0);
        chk(k, "tie_end_cnt", 128'(cnt[k]), 128'(cnt_m[k]));
    endtask

    task automatic reset_mid(input int k);
        i_req[k] = 1'b1; i_wea[k] = 1'b0; i_addr[k] = 12'h123;
        tick();
        tick();
        rst[k]   = 1'b1;
        i_req[k] = 1'b0;
        tick();
        chk_all_zero(k);
        rst[k]    = 1'b0;
        cnt_m[k]  = 0;
        last_m[k] = 1'b1;
        exp_i[k]  = '0;
        exp_d[k]  = '0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk(k, "post_rst_i_ack", 128'(i_ack[k]), '0);
            chk(k, "post_rst_d_ack", 128'(d_ack[k]), '0);
            chk(k, "post_rst_busy", 128'(busy[k]), '0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int k = 0; k < 2; k++) begin
            rst[k]   = 1'b1;
            i_req[k] = 1'b0; i_wea[k] = 1'b0; i_addr[k] = '0; i_wdata[k] = '0;
            d_req[k] = 1'b0; d_wea[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
            sram_rd[k] = '0;
            cnt_m[k]   = 0;
            last_m[k]  = 1'b1;
            exp_i[k]   = '0;
            exp_d[k]   = '0;
        end
        tick();
        tick();
        for (int k = 0; k < 2; k++) rst[k] = 1'b0;

        for (int k = 0; k < 2; k++) begin
            chk_all_zero(k);
            lone(k, 1'b0, 1'b0, 12'h010, '0);
            lone(k, 1'b1, 1'b1, 12'h3FF, 128'h1234);
            repeat (6) lone(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            12'($urandom()), rnd128());
            tie(k, 20);
            lone(k, 1'($urandom_range(0, 1)), 1'b0, 12'($urandom()), rnd128());
            reset_mid(k);
            lone(k, 1'b0, 1'b0, 12'h055, '0);
            tie(k, 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single refill/writeback port of the backing SRAM (128-bit line interface) between the instruction-side and data-side caches. Each requester issues one line read or line write at a time over a req/ack handshake. The arbiter latches the winner's command, drives the SRAM for exactly one cycle, and waits out the SRAM read latency. It then returns the line and a one-cycle ack. It sits between both `Cache_sets` instances and the SRAM macro.

## Interface
- `SRAM_ADDR_BIT`, 12: line address width.
- `SRAM_DATA_BIT`, 128: line width.
- `SRAM_LAT`, 1: SRAM read latency in cycles (≥1).
- `CNT_BIT`, 32: contention counter width.

Ports:
- `clk_sys_i` in 1: system clock.
- `rst_sys_i` in 1: synchronous, active-high reset.
- `I_req_i` / `D_req_i` in 1: access request; held until ack.
- `I_wea_i` / `D_wea_i` in 1: 1 = line write, 0 = line read.
- `I_addr_i` / `D_addr_i` in SRAM_ADDR_BIT: line address.
- `I_data_i` / `D_data_i` in SRAM_DATA_BIT: write line.
- `I_ack_o` / `D_ack_o` out 1: one-cycle completion pulse.
- `I_data_o` / `D_data_o` out SRAM_DATA_BIT: read line, valid while ack is high and held afterwards.
- `SRAM_ena_o`, `SRAM_wea_o` out 1: SRAM strobe and write enable.
- `SRAM_addr_o` out SRAM_ADDR_BIT: SRAM address.
- `SRAM_data_o` out SRAM_DATA_BIT: SRAM write data.
- `SRAM_data_i` in SRAM_DATA_BIT: SRAM read data.
- `busy_o` out 1: high in any state other than IDLE.
- `conflict_cnt_o` out CNT_BIT: saturating contention counter.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if either req is high, pick a winner, latch its wea/addr/data and the grant id, go to ISSUE. Otherwise stay.
  - ISSUE: `SRAM_ena_o`=1 with the latched wea/addr/data for exactly this cycle. Load the wait counter with SRAM_LAT−1 and go to WAIT.
  - WAIT: count down. In the last WAIT cycle (counter 0):
    - read: `SRAM_data_i` is captured into the granted requester's data register;
    - write: no capture;
    - go to RESP.
  - RESP: granted `X_ack_o`=1, then go to IDLE.
- Latching: command fields are sampled only at grant. Later changes to a requester's inputs are ignored until its ack.
- Requester rule: drop req at the edge ending the ack cycle. A req still high in the following IDLE cycle is treated as a new request.
- A req dropped mid-transaction does not abort it. The transaction completes and the ack still pulses.
- Arbitration, single request: that requester wins.
- Arbitration, both requesting: decided by the configuration in the Configuration section.
- `conflict_cnt_o` increments by 1 in each IDLE cycle where both req are high. It saturates at all-ones and never wraps.
- Non-granted `X_data_o` holds its previous value.

## Timing
- Read, req rising in IDLE cycle t:
  - ISSUE at t+1;
  - WAIT from t+2 to t+1+SRAM_LAT;
  - ack at t+2+SRAM_LAT (t+3 when SRAM_LAT=1).
- Write: same schedule. The SRAM write occurs at the ISSUE edge.
- Throughput: 3+SRAM_LAT cycles per access, including the mandatory IDLE cycle.
- All outputs are registered.
- Reset values (all outputs 0):
  - ack outputs, SRAM_* outputs, data outputs, `busy_o`, `conflict_cnt_o`;
  - FSM = IDLE;
  - last-grant register = D.
- Reset mid-operation:
  - outputs take their reset values at the next edge;
  - no ack is issued for the aborted access;
  - a write already strobed in ISSUE is not undone.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin. On a tie, the requester not granted last time wins. The last-grant register updates on every grant. After reset, I wins the first tie.
- Undefined: fixed priority. D always wins a tie. The last-grant register is omitted.
- Both modes: a lone requester is granted immediately.

## Structure
- Shared header package holds:
  - the FSM state encodings (`ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`, `ARB_RESP`);
  - the grant-id constants (`ARB_GNT_I`=0, `ARB_GNT_D`=1).
- One sub-module, `sram_arb_pick`: a combinational picker.
  - Inputs: two reqs and the last grant.
  - Output: winner id.
  - Contains the `SRAM_ARB_RR_EN` selection.
- FSM, latches, wait counter and contention counter live in the top module.

## Test plan
- Lone I read, addr 0x010, SRAM returns 0xA5…A5: `SRAM_ena_o` high only at t+1 with addr 0x010 and wea 0; `I_ack_o` at t+3 with `I_data_o`=0xA5…A5; `D_ack_o` stays 0.
- Lone D write, addr 0x3FF, data 0x1234: `SRAM_ena_o`=`SRAM_wea_o`=1 at t+1 with that addr/data; `D_ack_o` at t+3; `D_data_o` unchanged.
- Both req held continuously:
  - with `SRAM_ARB_RR_EN`, grants alternate I,D,I,D;
  - without it, D is granted every time;
  - `conflict_cnt_o` counts the tie IDLE cycles.
- SRAM_LAT=3, single read: ack at t+5; data captured from `SRAM_data_i` in the t+4 cycle only.
- `rst_sys_i` asserted in the WAIT cycle: next cycle all outputs 0 and FSM IDLE; no ack ever appears for that access.
- Force `conflict_cnt_o` to all-ones minus 1 with CNT_BIT=4, then apply three more tie IDLE cycles: counter stops at 0xF.
